// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if
// Frame delivery interface between the frame controller and its consumer.
//   frm_valid : complete, checksum-good frame is held (controller -> consumer)
//   frm_ready : consumer accepts the held frame      (consumer -> controller)
//   frm_len   : payload length of the held frame     (controller -> consumer)
//   rd_addr   : payload buffer read index            (consumer -> controller)
//   rd_data   : payload byte at rd_addr, combinational (controller -> consumer)
// Modports: master = frame controller, slave = frame consumer.
interface uart_rx_frame_ctrl_if;
  logic       frm_valid;
  logic       frm_ready;
  logic [7:0] frm_len;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output frm_valid, frm_len, rd_data,
    input  frm_ready, rd_addr
  );

  modport slave (
    input  frm_valid, frm_len, rd_data,
    output frm_ready, rd_addr
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Assembles UART bytes into frames of the form SOF, LEN, PAYLOAD[LEN], CHK
// where CHK is the XOR of LEN and all payload bytes. A good frame is held in
// the payload buffer until the consumer accepts it.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   rx_done_tick  : one-cycle byte strobe from the UART receiver
//   rx_data       : received byte, valid with rx_done_tick
//   s_tick        : 16x baud oversample tick (used only by the inter-byte timer)
//   frm           : frame delivery interface (master modport)
//   err_len/chk/tmo/ovr : one-cycle registered error pulses
//   busy          : high whenever a frame is in progress or held
// Optional feature: define FRAME_TIMEOUT_EN to enable the inter-byte timeout
// (TMO_TICKS s_tick pulses). Without it err_tmo is tied low and a partial
// frame waits indefinitely.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SOF       = 8'hA5,
  parameter int         TMO_TICKS = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rx_done_tick,
  input  logic [7:0]                  rx_data,
  input  logic                        s_tick,
  uart_rx_frame_ctrl_if.master        frm,
  output logic                        err_len,
  output logic                        err_chk,
  output logic                        err_tmo,
  output logic                        err_ovr,
  output logic                        busy
);

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CHK, HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] chk_q, chk_d;
  logic       err_len_q, err_len_d;
  logic       err_chk_q, err_chk_d;
  logic       err_ovr_q, err_ovr_d;
  logic       mem_we;
  logic [7:0] mem_q [MAX_LEN];

`ifdef FRAME_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_TICKS - 1);
  logic [15:0] tmr_q, tmr_d;
  logic        err_tmo_q, err_tmo_d;
`else
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_ovr_d = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_done_tick && (rx_data == SOF)) state_d = LEN;
      end
      LEN: begin
        if (rx_done_tick) begin
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end else begin
            len_d   = rx_data;
            cnt_d   = 8'd0;
            chk_d   = rx_data;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (rx_done_tick) begin
          mem_we = 1'b1;
          chk_d  = chk_q ^ rx_data;
          // Count holds on the last byte so it never reaches MAX_LEN.
          if (cnt_q == (len_q - 8'd1)) state_d = CHK;
          else                         cnt_d   = cnt_q + 8'd1;
        end
      end
      CHK: begin
        if (rx_done_tick) begin
          if (rx_data == chk_q) begin
            state_d = HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      HOLD: begin
        // A byte is dropped even when it coincides with the handshake.
        if (rx_done_tick)  err_ovr_d = 1'b1;
        if (frm.frm_ready) state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef FRAME_TIMEOUT_EN
    err_tmo_d = 1'b0;
    tmr_d     = tmr_q;
    if ((state_q == LEN) || (state_q == PAYLOAD) || (state_q == CHK)) begin
      // A byte on the expiring tick wins: it is processed and the timer restarts.
      if (rx_done_tick) begin
        tmr_d = 16'd0;
      end else if (s_tick) begin
        if (tmr_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
          tmr_d     = 16'd0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
    end else begin
      // Every entry into a timed state comes from IDLE/LEN/PAYLOAD on a byte,
      // so holding zero outside them plus clearing on bytes covers state entry.
      tmr_d = 16'd0;
    end
`endif
  end

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      chk_q     <= 8'd0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_ovr_q <= err_ovr_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q     <= 16'd0;
      err_tmo_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      err_tmo_q <= err_tmo_d;
    end
  end
  assign err_tmo = err_tmo_q;
`else
  assign err_tmo = 1'b0;
`endif

  // Payload buffer (data only, no reset)
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[AW-1:0]] <= rx_data;
  end

  assign frm.frm_valid = (state_q == HOLD);
  assign frm.frm_len   = len_q;
  assign frm.rd_data   = (frm.rd_addr < MAX_LEN_B) ? mem_q[frm.rd_addr[AW-1:0]] : 8'h00;
  assign busy          = (state_q != IDLE);
  assign err_len       = err_len_q;
  assign err_chk       = err_chk_q;
  assign err_ovr       = err_ovr_q;

endmodule
